and_verilog: RTL and testbench

AND_VERILOG -- requirements
Module: and_verilog

---
 rtl/and_verilog.sv | 66 ++++++
 tb/tb_and_verilog.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/and_verilog.sv
// Pipelined bitwise AND with registered all-ones flag, output valid tracking
// and a saturating counter of all-ones results reaching the output.
module and_verilog #(
    parameter int WIDTH = 1,
    parameter int STAGES = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             c_valid,
    output logic             c_all,
    output logic [CNT_W-1:0] hit_count
);

    logic [WIDTH-1:0] data_q  [STAGES];
    logic             all_q   [STAGES];
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] and_ab;
    logic             enter_all;
    logic             enter_valid;

    assign and_ab = a & b;

    // The counter looks at whatever is about to land in the last stage, so
    // hit_count stays aligned with c.
    generate
        if (STAGES == 1) begin : g_single
            assign enter_all   = &and_ab;
            assign enter_valid = 1'b1;
        end else begin : g_multi
            assign enter_all   = all_q[STAGES-2];
            assign enter_valid = valid_q[STAGES-2];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= '0;
                all_q[k]   <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            hit_count <= '0;
        end else begin
            data_q[0]  <= and_ab;
            all_q[0]   <= &and_ab;
            valid_q[0] <= 1'b1;
            for (int k = 1; k < STAGES; k++) begin
                data_q[k]  <= data_q[k-1];
                all_q[k]   <= all_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
            if (enter_all && enter_valid && (hit_count != {CNT_W{1'b1}})) begin
                hit_count <= hit_count + CNT_W'(1);
            end
        end
    end

    assign c       = data_q[STAGES-1];
    assign c_all   = all_q[STAGES-1];
    assign c_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_and_verilog.sv
// Scoreboard bench for and_verilog: a 1-bit single-stage instance and an
// 8-bit three-stage instance with a 2-bit hit counter share clock and reset.
module tb_and_verilog;

    logic       clk;
    logic       rst;
    logic       a1, b1, c1, cv1, ca1;
    logic [7:0] h1;
    logic [7:0] a8, b8, c8;
    logic       cv8, ca8;
    logic [1:0] h8;

    int vectors;
    int miscompares;

    logic       q1[$];
    logic [7:0] q8[$];
    logic [7:0] hit1_model;
    logic [1:0] hit8_model;

    and_verilog #(.WIDTH(1), .STAGES(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .c(c1), .c_valid(cv1), .c_all(ca1), .hit_count(h1)
    );

    and_verilog #(.WIDTH(8), .STAGES(3), .CNT_W(2)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8),
        .c(c8), .c_valid(cv8), .c_all(ca8), .hit_count(h8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        chk({tag, " w1 c"}, 64'(c1), 64'(0));
        chk({tag, " w1 c_all"}, 64'(ca1), 64'(0));
        chk({tag, " w1 c_valid"}, 64'(cv1), 64'(0));
        chk({tag, " w1 hit"}, 64'(h1), 64'(0));
        chk({tag, " w8 c"}, 64'(c8), 64'(0));
        chk({tag, " w8 c_all"}, 64'(ca8), 64'(0));
        chk({tag, " w8 c_valid"}, 64'(cv8), 64'(0));
        chk({tag, " w8 hit"}, 64'(h8), 64'(0));
    endtask

    task automatic clearModel();
        q1.delete();
        q8.delete();
        hit1_model = '0;
        hit8_model = '0;
    endtask

    // Pops a result only once it has had time to travel through the pipe.
    task automatic checkOutput();
        logic       e1;
        logic [7:0] e8;
        if (q1.size() >= 1) begin
            e1 = q1.pop_front();
            if ((&e1) === 1'b1 && hit1_model != 8'hFF) hit1_model++;
            chk("w1 c", 64'(c1), 64'(e1));
            chk("w1 c_all", 64'(ca1), 64'(&e1));
            chk("w1 c_valid", 64'(cv1), 64'(1));
        end else begin
            chk("w1 c_valid early", 64'(cv1), 64'(0));
        end
        chk("w1 hit_count", 64'(h1), 64'(hit1_model));
        if (q8.size() >= 3) begin
            e8 = q8.pop_front();
            if ((&e8) === 1'b1 && hit8_model != 2'b11) hit8_model++;
            chk("w8 c", 64'(c8), 64'(e8));
            chk("w8 c_all", 64'(ca8), 64'(&e8));
            chk("w8 c_valid", 64'(cv8), 64'(1));
        end else begin
            chk("w8 c early", 64'(c8), 64'(0));
            chk("w8 c_valid early", 64'(cv8), 64'(0));
        end
        chk("w8 hit_count", 64'(h8), 64'(hit8_model));
    endtask

    // Called with clk low; leaves with clk low again.
    task automatic applyStimulus(input logic a1v, input logic b1v,
                                 input logic [7:0] a8v, input logic [7:0] b8v);
        a1 = a1v;
        b1 = b1v;
        a8 = a8v;
        b8 = b8v;
        q1.push_back(a1v & b1v);
        q8.push_back(a8v & b8v);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        clearModel();
        #2;
        checkReset("reset start");
        repeat (2) @(posedge clk);
        #1;
        checkReset("reset held");

        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'hF0, 8'h3C);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55);
        applyStimulus(1'b1, 1'b0, 8'hFF, 8'h0F);
        applyStimulus(1'b1, 1'b1, 8'h81, 8'hFF);
        applyStimulus(1'bx, 1'b0, 8'h12, 8'h34);
        applyStimulus(1'bx, 1'b1, 8'h00, 8'hFF);
        applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);

        // Mid-stream reset between edges: outputs must clear immediately.
        #2;
        rst = 1'b1;
        #1;
        checkReset("async reset");
        @(posedge clk);
        #1;
        checkReset("reset clocked");
        @(negedge clk);
        rst = 1'b0;
        clearModel();

        // Saturation of the 2-bit counter with all-ones operands.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 8'hFF, 8'hFF);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hFE, 8'hFF);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
